// File: rtl/conv_pkg.sv
// Shared types and width/saturation helpers for the streaming 2D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp to the largest value representable in out_w bits.
    function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned out_w);
        logic [63:0] max_val;
        max_val = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Pixel input stream and result output stream of the convolution engine.
interface conv2d_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    modport master (
        output pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay: dout is the pixel pushed DEPTH enabled cycles earlier.
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK convolution over one IMG_HxIMG_W raster frame, with line buffers,
// two-stage multiply/accumulate pipeline, saturation and valid/ready backpressure.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_flip,
    input  logic                     coef_we,
    input  logic [$clog2(K*K)-1:0]   coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
    conv2d_stream_engine_if.slave    stream,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int KK     = K * K;
    localparam int ACC_W  = acc_width(DATA_W, KK);
    localparam int PROD_W = 2 * DATA_W;
    localparam int COL_W  = cnt_width(IMG_W);
    localparam int ROW_W  = cnt_width(IMG_H);

    state_t            state, state_nx;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              flip;
    logic [DATA_W-1:0] coef     [KK];
    logic [DATA_W-1:0] coef_sel [KK];
    logic [DATA_W-1:0] win      [KK];
    logic [DATA_W-1:0] lb_out   [K-1];
    logic [DATA_W-1:0] col_in   [K];
    logic [PROD_W-1:0] prod     [KK];
    logic              win_vld, win_last, prod_vld, prod_last;
    logic [ACC_W-1:0]  sum;
    logic              advance, accept, col_end, row_end, frame_end, win_ok;

    assign advance   = !stream.out_valid || stream.out_ready;
    assign accept    = stream.pix_valid && stream.pix_ready;
    assign col_end   = (col == COL_W'(IMG_W - 1));
    assign row_end   = (row == ROW_W'(IMG_H - 1));
    assign frame_end = col_end && row_end;
    assign win_ok    = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        stream.pix_ready = 1'b0;
        busy             = 1'b0;
        frame_done       = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy             = 1'b1;
                stream.pix_ready = advance;
                if (stream.pix_valid && advance && frame_end) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (stream.out_valid && stream.out_ready && stream.out_last) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            flip <= 1'b0;
            for (int unsigned i = 0; i < KK; i++) coef[i] <= '0;
        end else if (state == IDLE) begin
            if (coef_we && (32'(coef_addr) < KK)) coef[coef_addr] <= coef_data;
            if (start) begin
                flip <= cfg_flip;
                col  <= '0;
                row  <= '0;
            end
        end else if (accept) begin
            col <= col_end ? '0 : col + COL_W'(1);
            if (col_end) row <= row_end ? '0 : row + ROW_W'(1);
        end
    end

    // Line buffer j delays by j+1 rows; window row K-1 is the current row.
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        logic [DATA_W-1:0] din;
        if (j == 0) begin : g_head
            assign din = stream.pix_data;
        end else begin : g_chain
            assign din = lb_out[j-1];
        end
        conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (din),
            .dout (lb_out[j])
        );
    end

    always_comb begin
        col_in[K-1] = stream.pix_data;
        for (int unsigned r = 0; r < K - 1; r++) col_in[r] = lb_out[K-2-r];
    end

    always_comb begin
        for (int unsigned i = 0; i < KK; i++) coef_sel[i] = flip ? coef[KK-1-i] : coef[i];
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < KK; i++) sum = sum + ACC_W'(prod[i]);
    end

    // Every stage advances together; a stalled output freezes the whole pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < KK; i++) begin
                win[i]  <= '0;
                prod[i] <= '0;
            end
            win_vld          <= 1'b0;
            win_last         <= 1'b0;
            prod_vld         <= 1'b0;
            prod_last        <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_last  <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                for (int unsigned r = 0; r < K; r++) begin
                    for (int unsigned c = 0; c < K - 1; c++) win[r*K+c] <= win[r*K+c+1];
                    win[r*K+K-1] <= col_in[r];
                end
            end
            win_vld   <= accept && win_ok;
            win_last  <= accept && frame_end;
            prod_vld  <= win_vld;
            prod_last <= win_last;
            if (win_vld) begin
                for (int unsigned i = 0; i < KK; i++)
                    prod[i] <= PROD_W'(win[i]) * PROD_W'(coef_sel[i]);
            end
            stream.out_valid <= prod_vld;
            stream.out_last  <= prod_vld && prod_last;
            if (prod_vld) stream.out_data <= OUT_W'(saturate(64'(sum), OUT_W));
        end
    end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench: random frames/kernels checked against a direct sliding-window model.
module tb_conv2d_stream_engine;
    localparam int DATA_W    = 8;
    localparam int IMG_W     = 4;
    localparam int IMG_H     = 4;
    localparam int K         = 3;
    localparam int OUT_W     = 8;
    localparam int KK        = K * K;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int OUT_MAX   = 255;
    localparam int FIRST_PIX = (K - 1) * IMG_W + (K - 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cfg_flip = 1'b0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic       busy, frame_done;

    conv2d_stream_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) sif ();

    conv2d_stream_engine #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .OUT_W(OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_flip   (cfg_flip),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .stream     (sif),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         frames = 0;
    int         pix_cnt = 0;
    int         acc_cyc = 0;
    int         burst = 0;
    bit         seen_first = 1'b0;
    bit         held = 1'b0;
    bit         stall_en = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    logic [7:0] img [NPIX];
    int         mc  [KK];
    logic [8:0] exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake within bound, expected one", name);
        summary_and_finish();
    endtask

    // Reference: every valid output position, raster order, straight from the definition.
    task automatic push_expected(input bit flp);
        for (int y = 0; y <= IMG_H - K; y++) begin
            for (int x = 0; x <= IMG_W - K; x++) begin
                longint s;
                bit     last;
                s = 0;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        int t;
                        t = ky * K + kx;
                        s += int'(img[(y + ky) * IMG_W + x + kx]) * mc[flp ? KK - 1 - t : t];
                    end
                last = (y == IMG_H - K) && (x == IMG_W - K);
                exp_q.push_back({last, 8'((s > OUT_MAX) ? OUT_MAX : s)});
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en && burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 4);
        if (burst > 0) begin
            sif.out_ready = 1'b0;
            burst--;
        end else begin
            sif.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            logic [8:0] e;
            logic       hs_last;
            if (start && !busy) begin
                pix_cnt    = 0;
                seen_first = 1'b0;
            end
            if (held) begin
                check("stall_valid", sif.out_valid, 1);
                check("stall_data", sif.out_data, held_data);
                check("stall_last", sif.out_last, held_last);
            end
            held      = sif.out_valid && !sif.out_ready;
            held_data = sif.out_data;
            held_last = sif.out_last;
            if (sif.out_valid && !sif.out_ready) check("stall_pix_ready", sif.pix_ready, 0);
            if (sif.pix_valid && sif.pix_ready) begin
                if (pix_cnt == FIRST_PIX) acc_cyc = cyc + 1;
                pix_cnt++;
            end
            if (sif.out_valid && !seen_first) begin
                seen_first = 1'b1;
                check("first_latency", cyc - acc_cyc, 2);
            end
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected no result", sif.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", sif.out_data, e[7:0]);
                    check("out_last", sif.out_last, e[8]);
                end
            end
            hs_last = sif.out_valid && sif.out_ready && sif.out_last;
            if (frame_done || hs_last) check("frame_done", frame_done, hs_last);
            if (frame_done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 8'(d);
        step();
        coef_we = 1'b0;
        if (a < KK) mc[a] = d;
    endtask

    task automatic feed_pixel(input logic [7:0] v);
        int n;
        n = 0;
        if ($urandom_range(0, 3) == 0) begin
            sif.pix_valid = 1'b0;
            step();
        end
        sif.pix_valid = 1'b1;
        sif.pix_data  = v;
        forever begin
            @(negedge clk);
            if (sif.pix_ready) break;
            n++;
            if (n > 500) timeout("pixel_accept");
        end
        step();
        sif.pix_valid = 1'b0;
    endtask

    task automatic run_frame(input bit flp, input bit with_coef, input int cdata, input bit inject);
        int prev;
        int n;
        prev = done_cnt;
        n    = 0;
        if (with_coef) mc[KK-1] = cdata;
        push_expected(flp);
        start    = 1'b1;
        cfg_flip = flp;
        if (with_coef) begin
            coef_we   = 1'b1;
            coef_addr = 4'(KK - 1);
            coef_data = 8'(cdata);
        end
        step();
        start    = 1'b0;
        coef_we  = 1'b0;
        cfg_flip = ~flp;
        for (int p = 0; p < NPIX; p++) begin
            if (inject && p == 5) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 4'($urandom_range(0, KK - 1));
                coef_data = 8'($urandom);
                step();
                start   = 1'b0;
                coef_we = 1'b0;
            end
            feed_pixel(img[p]);
        end
        while (done_cnt == prev) begin
            @(negedge clk);
            n++;
            if (n > 500) timeout("frame_done_wait");
        end
        step();
        frames++;
        check("queue_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic random_image();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endtask

    initial begin
        sif.pix_valid = 1'b0;
        sif.pix_data  = '0;
        sif.out_ready = 1'b1;
        for (int i = 0; i < KK; i++) mc[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", sif.pix_ready, 0);
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_out_last", sif.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b1;
        step();

        // Coefficients come out of reset as zero.
        random_image();
        run_frame(1'b0, 1'b0, 0, 1'b0);

        // Reference image, kernel 1..9; final coefficient written in the start cycle.
        img = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
        for (int a = 0; a < KK - 1; a++) write_coef(a, a + 1);
        run_frame(1'b0, 1'b1, 9, 1'b0);
        run_frame(1'b1, 1'b0, 0, 1'b0);

        // Saturation; out-of-range addresses must not disturb the file.
        for (int a = 0; a < KK; a++) write_coef(a, 255);
        write_coef(12, 77);
        write_coef(15, 3);
        for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
        run_frame(1'b0, 1'b0, 0, 1'b0);

        // Output backpressure bursts plus ignored start/coef writes while running.
        stall_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int a = 0; a < KK; a++) write_coef(a, (f == 3) ? $urandom : $urandom_range(0, 7));
            random_image();
            run_frame(1'($urandom_range(0, 1)), 1'b0, 0, 1'b1);
        end

        // Abort mid-frame with reset; coefficients and flip return to zero.
        random_image();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < 7; p++) feed_pixel(img[p]);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pix_ready", sif.pix_ready, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < KK; i++) mc[i] = 0;
        step();
        for (int a = 0; a < KK; a++) write_coef(a, $urandom_range(0, 15));
        random_image();
        run_frame(1'b1, 1'b0, 0, 1'b0);

        repeat (5) step();
        check("frame_done_count", done_cnt, frames);
        summary_and_finish();
    end
endmodule

// File: doc/conv2d_stream_engine.md
# conv2d_stream_engine

Parametrised streaming 2D convolution engine, the next generation of the fixed 2×2-output systolic convolution block: one IMG_H×IMG_W frame of pixels is streamed in raster order, a K×K kernel held in an internal coefficient file is applied, and all (IMG_H−K+1)×(IMG_W−K+1) valid-position results are streamed out with valid/ready backpressure. It sits between the input-array buffer and the result buffer in the convolution datapath. It replaces per-element address sequencing by the testbench with internal line buffers. It adds kernel-flip mode, output saturation and a start/done frame protocol.

## Interface
- DATA_W, 8: unsigned pixel and coefficient width
- IMG_W, 4: frame width in pixels (≥ K)
- IMG_H, 4: frame height in rows (≥ K)
- K, 3: kernel dimension (odd or even, ≥ 2)
- OUT_W, 8: output width; results saturate to 2^OUT_W−1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start pulse; honoured only in IDLE
- cfg_flip  in  1  1 = true convolution (kernel reversed), 0 = correlation; sampled on accepted start
- coef_we  in  1  coefficient write strobe; honoured only in IDLE
- coef_addr  in  clog2(K*K)  coefficient index, raster order (row·K+col)
- coef_data  in  DATA_W  coefficient value
- pix_valid  in  1  pixel present
- pix_ready  out  1  engine accepts pixel this cycle
- pix_data  in  DATA_W  pixel value, raster order
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  saturated result
- out_last  out  1  marks final result of frame
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse when last result accepted

## Operation
- FSM: IDLE → RUN on start; RUN → DRAIN after IMG_W·IMG_H-th pixel accepted; DRAIN → IDLE when out_last accepted (frame_done pulses that cycle). start outside IDLE ignored.
- Coefficient file K·K entries, written only in IDLE; writes during busy ignored; addr ≥ K·K ignored. Contents persist across frames.
- Pixel accepted when pix_valid && pix_ready; pix_ready = (state==RUN) && advance, where advance = !out_valid || out_ready.
- K−1 line buffers of IMG_W entries plus K×K window register shift on every accepted pixel; col/row counters wrap at IMG_W/IMG_H.
- Window valid when accepted pixel has row ≥ K−1 and col ≥ K−1; only then a result enters the pipeline.
- Flip: window element i multiplied by coef[K·K−1−i] when flip latched, else coef[i].
- Arithmetic: unsigned DATA_W×DATA_W products, full-precision sum width ACC_W = 2·DATA_W + clog2(K·K); no truncation before saturation; out_data = min(sum, 2^OUT_W−1).
- out_last set on result from window at row IMG_H−1, col IMG_W−1.

## Timing
- Reset values: state IDLE, counters 0, pix_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, frame_done 0, coefficients 0, flip latch 0.
- Pipeline: edge t accepts pixel completing a window → product register t+1 → saturated output register t+2; out_valid high after edge t+2 (latency 2).
- Throughput one result per clock with out_ready held high; no bubbles between rows beyond invalid-window positions.
- out_ready low with out_valid high: all stages and pix_ready freeze; out_data/out_last held stable.
- Simultaneous coef_we and start in IDLE: write takes effect, start accepted; new coefficient used by the frame.
- rst asserted mid-frame: immediate return to reset values; partial frame discarded; no frame_done.

## Structure
- Shared package conv_pkg: state enum (IDLE, RUN, DRAIN), ACC_W/counter-width functions, saturate function.
- One sub-module: conv_line_buffer (IMG_W-deep shift buffer per row, enable-gated), instantiated K−1 times.

## Test plan
- Image rows {1,2,3,4},{5,6,7,8},{1,2,1,2},{1,2,1,2}, kernel 1..9, flip=0 → out 138,167,… first result exactly 2 cycles after pixel (2,2) accepted; out_last on 4th.
- Same image, flip=1 → first result 142.
- All pixels 255, kernel all 255 → every result 255 (saturated; raw 585225).
- Randomised out_ready low bursts → results identical to unstalled run, pix_ready low during every stall, no duplicates or drops.
- rst pulled low after 7 pixels, then new start with fresh frame → clean output, no leftover results, frame_done once.
- coef_we during RUN and start during RUN → both ignored; results match original kernel.
